float_dot_sched: RTL

//  Sequences one float_mac instance to compute a dot product sum(a[i]*b[i]) over a streamed vector pair.
//  The accumulator hazard is hidden by round-robin interleaving of MAC_LAT partial sums in the MAC pipeline.

---
 rtl/float_dot_sched.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/float_dot_sched.sv
// Dot-product sequencer for one float_mac: MAC_LAT partial sums are interleaved
// round-robin through the MAC pipeline, then serially reduced through the same MAC.
module float_dot_sched #(
  parameter int E_BIT   = 8,
  parameter int F_BIT   = 23,
  parameter int MAC_LAT = 6,
  parameter int LEN_W   = 16,
  localparam int W      = 1 + E_BIT + F_BIT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_a,
  input  logic [W-1:0]     in_b,
  output logic             busy,
  output logic             res_valid,
  output logic [W-1:0]     res_data,
  output logic [W-1:0]     mac_mul_a,
  output logic [W-1:0]     mac_mul_b,
  output logic [W-1:0]     mac_add_in,
  output logic             mac_com,
  input  logic [W-1:0]     mac_out
);
  localparam int SW = $clog2(MAC_LAT);
  localparam int PW = $clog2(MAC_LAT + 1);
  localparam logic [W-1:0] ONE = {1'b0, 1'b0, {(E_BIT-1){1'b1}}, {F_BIT{1'b0}}};

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, REDUCE} state_t;
  state_t state_q, state_d;

  logic [LEN_W-1:0]   len_q, cnt;
  logic [SW-1:0]      slot, iss_slot, slot_inc, pidx, rk;
  logic               add_sel;
  logic [MAC_LAT-1:0] live;
  logic [W-1:0]       psum [MAC_LAT];
  logic [PW-1:0]      nlive, tmr, dcnt;
  logic               accept, last_acc, drain_end, red_end, cap_now;

  assign accept    = (state_q == ACCUM) && in_valid;
  assign last_acc  = accept && (cnt == len_q - LEN_W'(1));
  assign drain_end = (state_q == DRAIN) && (dcnt == PW'(MAC_LAT));
  assign red_end   = (state_q == REDUCE) && (tmr == PW'(MAC_LAT));
  // DRAIN cycle 0 still holds the final element on the MAC inputs; captures start at cycle 1
  assign cap_now   = (state_q == DRAIN) && (dcnt != '0) && live[iss_slot];
  assign slot_inc  = (slot == SW'(MAC_LAT - 1)) ? '0 : slot + SW'(1);
  assign in_ready  = (state_q == ACCUM);
  assign busy      = (state_q != IDLE);
  assign mac_com   = 1'b0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    mac_add_in = '0;
    unique case (state_q)
      IDLE:   if (start && len != '0) state_d = ACCUM;
      ACCUM: begin
        mac_add_in = add_sel ? mac_out : '0;
        if (last_acc) state_d = DRAIN;
      end
      DRAIN: begin
        mac_add_in = add_sel ? mac_out : '0;
        if (drain_end) state_d = REDUCE;
      end
      REDUCE: begin
        // first reduce op adds psum[0]; later ops chain the previous op's result
        if (tmr == '0 && rk != '0) mac_add_in = (rk == SW'(1)) ? psum[0] : mac_out;
        if (red_end) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q <= '0; cnt <= '0; slot <= '0; iss_slot <= '0; add_sel <= 1'b0;
      live <= '0; pidx <= '0; rk <= '0; nlive <= '0; tmr <= '0; dcnt <= '0;
      res_valid <= 1'b0; res_data <= '0; mac_mul_a <= '0; mac_mul_b <= '0;
      for (int i = 0; i < MAC_LAT; i++) psum[i] <= '0;
    end else begin
      res_valid <= 1'b0;
      mac_mul_a <= '0;
      mac_mul_b <= '0;
      unique case (state_q)
        IDLE: begin
          add_sel <= 1'b0;
          if (start) begin
            if (len == '0) begin
              res_data  <= '0;
              res_valid <= 1'b1;
            end else begin
              len_q <= len; cnt <= '0; slot <= '0; live <= '0; pidx <= '0;
            end
          end
        end
        ACCUM: begin
          iss_slot <= slot;
          slot     <= slot_inc;
          add_sel  <= live[slot];
          dcnt     <= '0;
          if (accept) begin
            mac_mul_a  <= in_a;
            mac_mul_b  <= in_b;
            live[slot] <= 1'b1;
            cnt        <= cnt + LEN_W'(1);
          end
        end
        DRAIN: begin
          iss_slot <= slot;
          slot     <= slot_inc;
          add_sel  <= 1'b0;
          dcnt     <= dcnt + PW'(1);
          // partials are packed densely so reduction only visits live slots
          if (cap_now) begin
            psum[pidx] <= mac_out;
            pidx       <= pidx + SW'(1);
          end
          if (drain_end) begin
            nlive <= PW'(pidx) + PW'(1);
            if (pidx != '0) begin
              mac_mul_a <= (pidx == SW'(1)) ? mac_out : psum[1];
              mac_mul_b <= ONE;
              rk        <= SW'(1);
              tmr       <= '0;
            end else begin
              rk  <= '0;
              tmr <= PW'(MAC_LAT);
            end
          end
        end
        REDUCE: begin
          tmr <= tmr + PW'(1);
          if (tmr == PW'(MAC_LAT - 1) && (PW'(rk) + PW'(1) < nlive)) begin
            mac_mul_a <= psum[rk + SW'(1)];
            mac_mul_b <= ONE;
            rk        <= rk + SW'(1);
            tmr       <= '0;
          end
          if (red_end) begin
            res_data  <= (rk == '0) ? psum[0] : mac_out;
            res_valid <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule
